seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder that computes A + B + cin over WIDTH/CHUNK clock cycles. Each cycle it adds one CHUNK-bit slice, carrying between slices through a carry register. It is the area-reduced, handshaked successor to the single-cycle half/full adder cells. It sits between a producer and a consumer, both of which use valid/ready handshakes, and it reports carry-out and signed overflow.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
NCHUNK (derived), WIDTH/CHUNK, number of slice cycles per operation.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  producer has operands on a, b, cin.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A (unsigned, or two's complement for ovf).
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  sum/cout/ovf hold a completed result.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  (A + B + cin) mod 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.
ovf  output  1  signed overflow: the operands' MSBs are equal and the sum MSB differs from them.

Behaviour:
- Single clock domain: one clock, clk; reset rst is asynchronous and active-high.
- Reset:
  - state = IDLE; out_valid = 0; sum = 0; cout = 0; ovf = 0; internal shift registers, carry register and slice counter = 0.
  - in_ready = 0 while rst is high.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On the edge where in_valid && in_ready: latch a into a_sh, b into b_sh, cin into the carry register, a[WIDTH-1] and b[WIDTH-1] into MSB registers; cnt = 0; go to RUN.
- RUN:
  - in_ready = 0.
  - Each edge: {c, s} = a_sh[CHUNK-1:0] + b_sh[CHUNK-1:0] + carry, a CHUNK+1-bit add.
  - sum_sh <= {s, sum_sh[WIDTH-1:CHUNK]}; a_sh and b_sh shift right by CHUNK; carry <= c; cnt++.
  - On the edge where cnt == NCHUNK-1:
    - Load output registers: sum <= final sum_sh value including this slice; cout <= c; ovf <= (amsb == bmsb) && (s[CHUNK-1] != amsb).
    - Set out_valid = 1; go to DONE.
- DONE:
  - out_valid = 1; in_ready = 0; in_valid is ignored.
  - sum, cout and ovf are held stable until the handshake.
  - On the edge where out_ready: out_valid <= 0; go to IDLE.
- Outputs are registered only. sum/cout/ovf change only on the RUN-to-DONE edge, and keep their last value after the handshake until the next completion.
- Latency: operands accepted at edge k give out_valid = 1 after edge k + NCHUNK.
- Throughput: with out_ready held at 1, one operation completes every NCHUNK + 2 cycles. The extra two cycles are the DONE handshake edge and the IDLE accept edge.
- NCHUNK = 1 (CHUNK == WIDTH) is legal: one RUN cycle, latency 1.
- cnt width = max(1, $clog2(NCHUNK)). cnt never exceeds NCHUNK-1.
- Reset asserted during RUN or DONE:
  - Aborts immediately; the in-flight result is lost and out_valid drops asynchronously.
  - After rst deasserts, the block is in IDLE with in_ready = 1 on the first cycle.
- in_valid held high in IDLE across consecutive operations: a new operand is accepted only in IDLE, never in the same edge as the DONE handshake.

Test Plan:
- WIDTH=16, CHUNK=4; a=0xFFFF, b=0x0001, cin=0 -> after 4 edges: out_valid=1, sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- a=0x1234, b=0x4321, cin=1 with out_ready held 0 for 5 cycles -> sum=0x5556, cout=0. Outputs are stable and in_ready=0 throughout. A pulse on in_valid during this wait is not accepted.
- Assert rst for 1 cycle at cnt=2 of an operation -> out_valid=0 and sum=0 immediately. Then in_ready=1; the next operation a=0x0003, b=0x0004 -> sum=0x0007 after 4 edges.
- Back-to-back with in_valid=out_ready=1: results arrive every 6 cycles.
- Random regression against the reference model a+b+cin for {WIDTH,CHUNK} = {16,4}, {16,16}, {8,1}, {32,8}, covering cin values of 0 and 1.

Source files
------------

// File: rtl/seq_chunk_adder_if.sv
// Handshake bundle for seq_chunk_adder: operand side (in_*) and result side (out_*).
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle A + B + cin adder that works CHUNK bits per clock, with valid/ready
// handshakes on both sides and registered sum, carry-out and signed overflow.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0]    S_IDLE   = 2'd0;
  localparam logic [1:0]    S_RUN    = 2'd1;
  localparam logic [1:0]    S_DONE   = 2'd2;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             amsb_r;
  logic             bmsb_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;

  logic [CHUNK:0]   slice_s;
  logic [WIDTH-1:0] sum_next_s;
  logic             last_s;
  logic             in_ready_s;

  // Slice adder; the new slice enters the result shift register from the top
  always_comb begin
    slice_s    = {1'b0, a_sh_r[CHUNK-1:0]} + {1'b0, b_sh_r[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, carry_r};
    sum_next_s = WIDTH'({slice_s[CHUNK-1:0], sum_sh_r} >> CHUNK);
    last_s     = (cnt_r == CNT_LAST);
  end

  // Operands are taken only in IDLE and never while reset is asserted
  always_comb begin
    if (rst) begin
      in_ready_s = 1'b0;
    end else if (state_r == S_IDLE) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  // Control FSM with operand, carry and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      sum_sh_r    <= '0;
      sum_r       <= '0;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      amsb_r      <= 1'b0;
      bmsb_r      <= 1'b0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            carry_r <= bus.cin;
            amsb_r  <= bus.a[WIDTH-1];
            bmsb_r  <= bus.b[WIDTH-1];
            cnt_r   <= '0;
            state_r <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_r   <= a_sh_r >> CHUNK;
          b_sh_r   <= b_sh_r >> CHUNK;
          sum_sh_r <= sum_next_s;
          carry_r  <= slice_s[CHUNK];
          if (last_s) begin
            // Signed overflow is judged on the MSB of the final slice
            sum_r       <= sum_next_s;
            cout_r      <= slice_s[CHUNK];
            ovf_r       <= (amsb_r == bmsb_r) && (slice_s[CHUNK-1] != amsb_r);
            out_valid_r <= 1'b1;
            cnt_r       <= '0;
            state_r     <= S_DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: directed vectors and a transaction-level model on a 16/4
// instance, plus operand sweeps on 16/16, 8/1 and 32/8 instances.
module tb_seq_chunk_adder;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   cmp_en   = 1'b0;
  bit   tp_en    = 1'b0;
  int   hs_q[$];

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(16)) bus ();
  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a result is due NCH edges after acceptance
  logic [16:0] p_full;
  logic        p_ovf;
  bit          m_busy, m_valid, m_cout, m_ovf;
  int          m_cd;
  logic [15:0] m_sum;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_cd <= 0;
      m_sum <= 16'h0; m_cout <= 1'b0; m_ovf <= 1'b0;
    end else if (m_valid) begin
      if (bus.out_ready) m_valid <= 1'b0;
    end else if (m_busy) begin
      if (m_cd == 1) begin
        m_busy <= 1'b0; m_valid <= 1'b1;
        m_sum <= p_full[15:0]; m_cout <= p_full[16]; m_ovf <= p_ovf;
      end
      m_cd <= m_cd - 1;
    end else if (bus.in_valid) begin
      m_busy <= 1'b1;
      m_cd   <= NCH;
      p_full <= {1'b0, bus.a} + {1'b0, bus.b} + {16'h0, bus.cin};
      p_ovf  <= (bus.a[15] == bus.b[15]) &&
                ((bus.a + bus.b + {15'h0, bus.cin}) >> 15 != {15'h0, bus.a[15]});
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_in_ready", bus.in_ready, (!rst && !m_busy && !m_valid));
      chk("m_out_valid", bus.out_valid, m_valid);
      chk("m_sum", bus.sum, m_sum);
      chk("m_cout", bus.cout, m_cout);
      chk("m_ovf", bus.ovf, m_ovf);
    end
    if (tp_en && bus.out_valid && bus.out_ready) hs_q.push_back(cyc);
  end

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input int hold, input logic [15:0] es, input logic ec,
                        input logic eo, input string nm);
    int n;
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin @(negedge clk); w++; end
    chk({nm, "_ready_wait"}, (w < 20), 1'b1);
    bus.a = ta; bus.b = tb_v; bus.cin = tc;
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    n = 0;
    while (n < 30) begin
      @(posedge clk); #1; n++;
      if (bus.out_valid) break;
    end
    chk({nm, "_latency"}, n, NCH);
    chk({nm, "_sum"}, bus.sum, es);
    chk({nm, "_cout"}, bus.cout, ec);
    chk({nm, "_ovf"}, bus.ovf, eo);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = (i == 2);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk({nm, "_hold_valid"}, bus.out_valid, 1'b1);
      chk({nm, "_hold_ready"}, bus.in_ready, 1'b0);
      chk({nm, "_hold_sum"}, bus.sum, es);
      chk({nm, "_hold_cout"}, bus.cout, ec);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_drop_valid"}, bus.out_valid, 1'b0);
    chk({nm, "_idle_ready"}, bus.in_ready, 1'b1);
    chk({nm, "_kept_sum"}, bus.sum, es);
  endtask

  // Operand sweeps on the other geometries, each with its own reset
  genvar g;
  for (g = 0; g < 3; g++) begin : gcfg
    localparam int W  = (g == 0) ? 16 : ((g == 1) ? 8 : 32);
    localparam int C  = (g == 0) ? 16 : ((g == 1) ? 1 : 8);
    localparam int NC = W / C;
    logic grst;
    bit   done = 1'b0;
    seq_chunk_adder_if #(.WIDTH(W)) gif ();
    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) gdut (.clk(clk), .rst(grst), .bus(gif));

    initial begin
      logic [W:0] full;
      logic       eovf;
      int         n;
      int         w;
      grst = 1'b1; gif.in_valid = 1'b0; gif.out_ready = 1'b1;
      gif.a = '0; gif.b = '0; gif.cin = 1'b0;
      repeat (2) @(posedge clk);
      #2 grst = 1'b0;
      for (int i = 0; i < 24; i++) begin
        if (i < 2) begin
          gif.a = (i == 0) ? {W{1'b1}} : {1'b0, {(W-1){1'b1}}};
          gif.b = W'(1);
        end else begin
          gif.a = W'({$urandom, $urandom});
          gif.b = W'({$urandom, $urandom});
        end
        gif.cin = i[0];
        full = {1'b0, gif.a} + {1'b0, gif.b} + {{W{1'b0}}, gif.cin};
        eovf = (gif.a[W-1] == gif.b[W-1]) && (full[W-1] != gif.a[W-1]);
        w = 0;
        while (!gif.in_ready && w < 20) begin @(negedge clk); w++; end
        chk($sformatf("g%0d_ready_wait", g), (w < 20), 1'b1);
        gif.in_valid = 1'b1;
        @(posedge clk); #2;
        gif.in_valid = 1'b0;
        n = 0;
        while (n < 60) begin
          @(posedge clk); #1; n++;
          if (gif.out_valid) break;
        end
        chk($sformatf("g%0d_latency", g), n, NC);
        chk($sformatf("g%0d_sum", g), gif.sum, full[W-1:0]);
        chk($sformatf("g%0d_cout", g), gif.cout, full[W]);
        chk($sformatf("g%0d_ovf", g), gif.ovf, eovf);
      end
      done = 1'b1;
    end
  end

  initial begin
    int w;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = 16'h0; bus.b = 16'h0; bus.cin = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    chk("post_rst_sum", bus.sum, 16'h0000);
    chk("post_rst_cout", bus.cout, 1'b0);
    chk("post_rst_ovf", bus.ovf, 1'b0);

    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0, "wrap");
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1, "posovf");
    run_op(16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1, "negovf");
    run_op(16'h1234, 16'h4321, 1'b1, 5, 16'h5556, 1'b0, 1'b0, "stall");

    // Abort an operation two slices in
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_sum", bus.sum, 16'h0000);
    chk("abort_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("abort_idle_ready", bus.in_ready, 1'b1);
    run_op(16'h0003, 16'h0004, 1'b0, 0, 16'h0007, 1'b0, 1'b0, "after_abort");

    // Back-to-back traffic with both handshakes held high
    tp_en = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
      @(posedge clk); #2;
    end
    tp_en = 1'b0;
    bus.in_valid = 1'b0;
    chk("tp_count", (hs_q.size() >= 5), 1'b1);
    for (int i = 1; i < hs_q.size(); i++) chk("tp_interval", hs_q[i] - hs_q[i-1], 6);
    repeat (10) @(posedge clk);

    w = 0;
    while (!(gcfg[0].done && gcfg[1].done && gcfg[2].done) && w < 5000) begin
      @(posedge clk); w++;
    end
    chk("sweeps_done", (w < 5000), 1'b1);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
